// File: rtl/fetch_stage.sv
// Instruction fetch stage plus the fetch/execute pipeline register.
// One memory request outstanding at a time; jal redirects come back from the control unit.
module fetch_stage #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_FETCH,
  input  logic [1:0]        pcsrc,
  input  logic [ADDR_W-1:0] jal_target,
  output logic [31:0]       instruction_EX,
  output logic [ADDR_W-1:0] pc_EX,
  output logic              valid_EX,
  output logic              stall_EX
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_f_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_ex_q;
  logic              valid_q;
  logic              stall_q;

  logic [ADDR_W-1:0] pc_inc;
  logic              redirect;

  assign pc_inc   = pc_f_q + ADDR_W'(1);
  assign redirect = valid_q & stall_FETCH & (pcsrc == 2'd1);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_f_q;
    case (state_q)
      S_IDLE:  imem_req = 1'b1;
      S_WAIT: begin
        if (imem_rvalid) begin
          imem_req  = 1'b1;
          imem_addr = redirect ? jal_target : pc_inc;
        end
      end
      S_DRAIN: imem_req = imem_rvalid;
      default: imem_req = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_f_q  <= RESET_PC;
      instr_q <= NOP;
      pc_ex_q <= '0;
      valid_q <= 1'b0;
      stall_q <= 1'b1;
    end else begin
      // A bubble is the default; only an accepted instruction overrides it.
      instr_q <= NOP;
      valid_q <= 1'b0;
      stall_q <= 1'b1;
      case (state_q)
        S_IDLE: state_q <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid && !redirect) begin
            instr_q <= imem_rdata;
            pc_ex_q <= pc_f_q;
            valid_q <= 1'b1;
            stall_q <= 1'b0;
            pc_f_q  <= pc_inc;
          end else if (redirect) begin
            pc_f_q <= jal_target;
            // The wrong-path request is still in flight; wait for it before reissuing.
            if (!imem_rvalid) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) state_q <= S_WAIT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instruction_EX = instr_q;
  assign pc_EX          = pc_ex_q;
  assign valid_EX       = valid_q;
  assign stall_EX       = stall_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed edge-indexed vectors plus randomized programs
// checked against an instruction-stream timing model.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          HMAX = 512;
  localparam int          K_EX  = 0;
  localparam int          K_ISS = 1;
  localparam int          K_EX2 = 2;

  typedef struct {
    int          lat;
    bit          has_jal;
    int          edge_n;
    int          kind;
    bit          exp_v;
    logic [11:0] exp_val;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        imem_req,   imem_req2;
  logic [11:0] imem_addr,  imem_addr2;
  logic        imem_rvalid, imem_rvalid2;
  logic [31:0] imem_rdata,  imem_rdata2;
  logic        stall_FETCH;
  logic [1:0]  pcsrc;
  logic [11:0] jal_target;
  logic [31:0] instruction_EX, instruction_EX2;
  logic [11:0] pc_EX, pc_EX2;
  logic        valid_EX, valid_EX2;
  logic        stall_EX, stall_EX2;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_FETCH(stall_FETCH), .pcsrc(pcsrc), .jal_target(jal_target),
    .instruction_EX(instruction_EX), .pc_EX(pc_EX),
    .valid_EX(valid_EX), .stall_EX(stall_EX)
  );

  fetch_stage #(.ADDR_W(12), .RESET_PC(12'hFFE)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .stall_FETCH(1'b0), .pcsrc(2'd0), .jal_target(12'h000),
    .instruction_EX(instruction_EX2), .pc_EX(pc_EX2),
    .valid_EX(valid_EX2), .stall_EX(stall_EX2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Environment state: program (jal table), memory latency, history per edge.
  int          lat = 1;
  bit          noise = 0;
  bit          is_jal [4096];
  logic [11:0] jal_tgt [4096];
  int          edge_cnt = 0;
  bit          hv   [HMAX];
  logic [11:0] hpc  [HMAX];
  bit          ireq [HMAX];
  logic [11:0] iaddr[HMAX];
  bit          hv2  [HMAX];
  logic [11:0] hpc2 [HMAX];

  // Memory, control unit and reference model all step together once per edge.
  bit          cap, cap2, rv_at, pend;
  logic [11:0] cap_addr, cap2_addr, paddr, m_pc, ex_a;
  int          cnt, m_next;

  initial begin : drv
    pend = 0; cnt = 0; paddr = '0; m_pc = '0; m_next = 2;
    forever begin
      @(posedge clk);
      cap       = imem_req && !rst;
      cap_addr  = imem_addr;
      rv_at     = imem_rvalid;
      cap2      = imem_req2 && !rst;
      cap2_addr = imem_addr2;
      if (rst) edge_cnt = 0;
      else     edge_cnt++;
      if (!rst && edge_cnt < HMAX) begin
        ireq[edge_cnt]  = imem_req;
        iaddr[edge_cnt] = imem_addr;
      end
      if (cap) check("one_outstanding", 32'(pend && !rv_at), 32'd0);
      #1;
      if (rst) begin
        pend = 0;
        imem_rvalid  = 1'b0;
        imem_rvalid2 = 1'b0;
        m_pc   = 12'h000;
        m_next = lat + 1;
      end else begin
        if (imem_rvalid) pend = 0;
        if (cap) begin pend = 1; paddr = cap_addr; cnt = 0; end
        if (pend) cnt++;
        imem_rvalid  = pend && (cnt == lat);
        imem_rdata   = {20'h0, paddr};
        imem_rvalid2 = cap2;
        imem_rdata2  = {20'h0, cap2_addr};
        if (edge_cnt < HMAX) begin
          hv[edge_cnt]   = valid_EX;
          hpc[edge_cnt]  = pc_EX;
          hv2[edge_cnt]  = valid_EX2;
          hpc2[edge_cnt] = pc_EX2;
        end
        // Each instruction follows its predecessor by lat edges, or 2*lat after a jal.
        if (edge_cnt == m_next) begin
          check("model_valid", 32'(valid_EX), 32'd1);
          check("model_pc", 32'(pc_EX), 32'(m_pc));
          check("model_instr", instruction_EX, {20'h0, m_pc});
          check("model_stall", 32'(stall_EX), 32'd0);
          m_next = m_next + (is_jal[m_pc] ? 2 * lat : lat);
          m_pc   = is_jal[m_pc] ? jal_tgt[m_pc] : m_pc + 12'd1;
        end else begin
          check("model_bubble_valid", 32'(valid_EX), 32'd0);
          check("model_bubble_instr", instruction_EX, NOP);
          check("model_bubble_stall", 32'(stall_EX), 32'd1);
        end
      end
      ex_a       = instruction_EX[11:0];
      jal_target = jal_tgt[ex_a];
      if (is_jal[ex_a]) begin
        stall_FETCH = 1'b1;
        pcsrc       = 2'd1;
      end else if (noise) begin
        stall_FETCH = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       pcsrc = 2'd0;
          1:       pcsrc = 2'd2;
          default: pcsrc = 2'd3;
        endcase
      end else begin
        stall_FETCH = 1'b0;
        pcsrc       = 2'd0;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run(input int l, input bit j, input bit nz, input int n);
    lat   = l;
    noise = nz;
    for (int i = 0; i < 4096; i++) begin
      is_jal[i]  = 1'b0;
      jal_tgt[i] = 12'h000;
    end
    if (j) begin
      is_jal[4]  = 1'b1;
      jal_tgt[4] = 12'h020;
    end
    pulse_reset();
    repeat (n) @(posedge clk);
    #2;
  endtask

  vec_t tbl[$];

  initial begin : main
    int  cur_lat;
    bit  cur_jal;
    bit  act_v;
    logic [11:0] act_val;

    rst = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = '0;
    imem_rvalid2 = 1'b0; imem_rdata2 = '0;
    stall_FETCH = 1'b0; pcsrc = 2'd0; jal_target = '0;

    // lat, has_jal, edge, kind, expected valid/req, expected pc/addr
    tbl.push_back('{1, 0, 1, K_EX,  0, 12'h000});
    tbl.push_back('{1, 0, 2, K_EX,  1, 12'h000});
    tbl.push_back('{1, 0, 3, K_EX,  1, 12'h001});
    tbl.push_back('{1, 0, 4, K_EX,  1, 12'h002});
    tbl.push_back('{1, 0, 1, K_ISS, 1, 12'h000});
    tbl.push_back('{1, 0, 2, K_ISS, 1, 12'h001});
    tbl.push_back('{1, 0, 3, K_ISS, 1, 12'h002});
    tbl.push_back('{1, 0, 1, K_EX2, 0, 12'h000});
    tbl.push_back('{1, 0, 2, K_EX2, 1, 12'hFFE});
    tbl.push_back('{1, 0, 3, K_EX2, 1, 12'hFFF});
    tbl.push_back('{1, 0, 4, K_EX2, 1, 12'h000});
    tbl.push_back('{1, 0, 5, K_EX2, 1, 12'h001});
    tbl.push_back('{3, 0, 1, K_ISS, 1, 12'h000});
    tbl.push_back('{3, 0, 2, K_ISS, 0, 12'h000});
    tbl.push_back('{3, 0, 3, K_EX,  0, 12'h000});
    tbl.push_back('{3, 0, 4, K_EX,  1, 12'h000});
    tbl.push_back('{3, 0, 4, K_ISS, 1, 12'h001});
    tbl.push_back('{3, 0, 5, K_EX,  0, 12'h000});
    tbl.push_back('{3, 0, 6, K_EX,  0, 12'h000});
    tbl.push_back('{3, 0, 7, K_EX,  1, 12'h001});
    tbl.push_back('{3, 0, 10, K_EX, 1, 12'h002});
    tbl.push_back('{1, 1, 5, K_EX,  1, 12'h003});
    tbl.push_back('{1, 1, 6, K_EX,  1, 12'h004});
    tbl.push_back('{1, 1, 7, K_ISS, 1, 12'h020});
    tbl.push_back('{1, 1, 7, K_EX,  0, 12'h000});
    tbl.push_back('{1, 1, 8, K_EX,  1, 12'h020});
    tbl.push_back('{1, 1, 9, K_EX,  1, 12'h021});
    tbl.push_back('{3, 1, 16, K_EX, 1, 12'h004});
    tbl.push_back('{3, 1, 17, K_ISS, 0, 12'h000});
    tbl.push_back('{3, 1, 18, K_ISS, 0, 12'h000});
    tbl.push_back('{3, 1, 19, K_ISS, 1, 12'h020});
    tbl.push_back('{3, 1, 17, K_EX, 0, 12'h000});
    tbl.push_back('{3, 1, 19, K_EX, 0, 12'h000});
    tbl.push_back('{3, 1, 21, K_EX, 0, 12'h000});
    tbl.push_back('{3, 1, 22, K_EX, 1, 12'h020});
    tbl.push_back('{3, 1, 25, K_EX, 1, 12'h021});

    cur_lat = -1;
    cur_jal = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].lat != cur_lat || tbl[i].has_jal != cur_jal) begin
        cur_lat = tbl[i].lat;
        cur_jal = tbl[i].has_jal;
        start_run(cur_lat, cur_jal, 1'b0, 30);
      end
      case (tbl[i].kind)
        K_EX:    begin act_v = hv[tbl[i].edge_n];   act_val = hpc[tbl[i].edge_n];   end
        K_ISS:   begin act_v = ireq[tbl[i].edge_n]; act_val = iaddr[tbl[i].edge_n]; end
        default: begin act_v = hv2[tbl[i].edge_n];  act_val = hpc2[tbl[i].edge_n];  end
      endcase
      check($sformatf("vec%0d_valid", i), 32'(act_v), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) check($sformatf("vec%0d_pc", i), 32'(act_val), 32'(tbl[i].exp_val));
    end

    // Reset asserted while draining a jal: outputs clear immediately, fetch restarts at RESET_PC.
    start_run(3, 1'b1, 1'b0, 17);
    @(negedge clk);
    check("drain_no_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_instr", instruction_EX, NOP);
    check("rst_valid", 32'(valid_EX), 32'd0);
    check("rst_stall", 32'(stall_EX), 32'd1);
    check("rst_pc_ex", 32'(pc_EX), 32'd0);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", 32'(imem_addr), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("restart_first_valid", 32'(hv[4]), 32'd1);
    check("restart_first_pc", 32'(hpc[4]), 32'd0);

    // Random programs, latencies and control-unit noise, with a mid-run reset.
    for (int r = 0; r < 6; r++) begin
      lat   = 1 + $urandom_range(0, 3);
      noise = 1'b1;
      for (int i = 0; i < 4096; i++) begin
        is_jal[i]  = ($urandom_range(0, 7) == 0);
        jal_tgt[i] = 12'($urandom);
      end
      pulse_reset();
      repeat ($urandom_range(60, 200)) @(posedge clk);
      pulse_reset();
      repeat (150) @(posedge clk);
      #2;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and fetch/execute pipeline register for the single-issue core; sits directly upstream of the control unit. Tracks the fetch PC and issues word reads to instruction memory over a request/response handshake with one request outstanding. It presents one instruction per cycle, or a NOP bubble, to the decode/execute stage, and redirects on `jal` when the control unit raises `stall_FETCH` with `pcsrc==1`.

## Interface
- `RESET_PC`, default 12'h000: word address fetched first after reset.
- `ADDR_W`, default 12: instruction-memory word-address width; `pc_F` and `pc_EX` are this width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req` out 1: issue strobe; the memory samples `imem_addr` on this edge.
- `imem_addr` out ADDR_W: word address of the issued request.
- `imem_rvalid` in 1: response valid; arrives at least 1 cycle after its request.
- `imem_rdata` in 32: instruction word, meaningful only with `imem_rvalid`.
- `stall_FETCH` in 1: from control unit, combinational on `instruction_EX`.
- `pcsrc` in 2: from control unit; 1 = jal; 0, 2 and 3 = sequential.
- `jal_target` in ADDR_W: word target of the `jal` currently in EX.
- `instruction_EX` out 32: registered instruction to the control unit and EX.
- `pc_EX` out ADDR_W: word PC of `instruction_EX`.
- `valid_EX` out 1: `instruction_EX` is a real instruction.
- `stall_EX` out 1: `~valid_EX`; feeds the control unit to suppress regwrite on bubbles.

## Operation
- Bubble: `instruction_EX`=32'h00000013 (NOP), `valid_EX`=0. A bubble is loaded on every edge where no instruction is accepted, so each instruction occupies EX for exactly one cycle.
- `redirect` = `valid_EX & stall_FETCH & (pcsrc==2'd1)`.
- At most one request outstanding. `pc_F` holds the address of the outstanding or next request.
- State IDLE (after reset):
  - `imem_req`=1, `imem_addr`=`pc_F`; go to WAIT.
  - `imem_rvalid` ignored, so a stale response after reset is dropped.
- State WAIT:
  - No `rvalid`, no `redirect`: `imem_req`=0; load bubble; hold state.
  - `rvalid`, no `redirect`: load `instruction_EX`=`rdata`, `pc_EX`=`pc_F`, `valid_EX`=1. Set `pc_F`=`pc_F`+1. Same cycle: `imem_req`=1, `imem_addr`=`pc_F`+1. Stay in WAIT.
  - `rvalid` with `redirect`: drop `rdata` (the instruction after the jal); load bubble. Set `pc_F`=`jal_target`. Same cycle: `imem_req`=1, `imem_addr`=`jal_target`. Stay in WAIT.
  - `redirect`, no `rvalid`: set `pc_F`=`jal_target`, load bubble, go to DRAIN.
- State DRAIN:
  - No `rvalid`: `imem_req`=0, load bubble.
  - `rvalid`: drop `rdata`, load bubble, `imem_req`=1, `imem_addr`=`pc_F`, go to WAIT.
  - `redirect` cannot occur because EX holds a bubble; it is ignored.
- PC arithmetic is modulo 2^ADDR_W: 'hFFF+1 = 'h000. `pcsrc` 2 and 3 are reserved and behave as sequential.
- `imem_req` and `imem_addr` are combinational from state, `pc_F`, `imem_rvalid`, `redirect` and `jal_target`. All other outputs are registered.

## Timing
- Reset, asynchronous and immediate: state=IDLE, `pc_F`=`RESET_PC`, `instruction_EX`=NOP, `pc_EX`=0, `valid_EX`=0, `stall_EX`=1. `imem_req` is 1 while IDLE, including during reset, but no issue counts until the first edge after `rst` falls.
- First issue occurs on the first edge after reset release.
- With 1-cycle memory, `valid_EX` first rises 2 edges after release, then sustains 1 instruction/cycle.
- With N-cycle memory: 1 instruction every N cycles, N-1 bubbles between.
- Jal penalty with 1-cycle memory: exactly 1 bubble. A jal on `pc_EX`=A puts `jal_target` in EX two cycles later.
- Reset mid-DRAIN or mid-WAIT discards the outstanding request. The late response lands in IDLE or in the new WAIT; the memory model must not respond after reset.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory returning `rdata`={20'h0, addr} -> `imem_addr` 0,1,2,… on consecutive cycles; `pc_EX`=0,1,2 with `valid_EX`=1 every cycle from the 2nd edge after release.
- 3-cycle memory -> `valid_EX` high 1 cycle in 3; between them `instruction_EX`=32'h00000013 and `stall_EX`=1; `pc_EX` increments by 1 per valid instruction.
- 1-cycle memory, jal at addr 4 with `jal_target`=0x20 -> `pc_EX` sequence 3,4,bubble,0x20,0x21; the word at 5 is never valid; `imem_addr`=0x20 in the cycle `pc_EX`=4.
- 3-cycle memory, same jal -> DRAIN entered; response for addr 5 dropped; next `imem_req` has `imem_addr`=0x20; `pc_EX`=0x20 is the next valid instruction after 4.
- RESET_PC='hFFE, 1-cycle memory -> `pc_EX` 'hFFE,'hFFF,'h000,'h001.
- Assert `rst` during DRAIN -> outputs take reset values within the same cycle; after release, fetch restarts at RESET_PC; no dropped or duplicated `valid_EX`.
